regincr_nstage_vr: RTL and testbench



---
 rtl/regincr_pkg.sv | 13 +
 rtl/regincr_stage_vr.sv | 41 ++++
 rtl/regincr_nstage_vr.sv | 94 +++++++++
 tb/tb_regincr_nstage_vr.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regincr_pkg.sv
// regincr_pkg
//   Shared helpers for the N-stage registered incrementer.
//   count_width(n) : bits needed to hold an occupancy value in 0..n,
//                    i.e. $clog2(n+1), never less than 1.
package regincr_pkg;

    function automatic int count_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/regincr_stage_vr.sv
// regincr_stage_vr
//   One elastic pipeline stage: a valid bit, a message register and the
//   constant adder feeding it.  When rdy is high the stage loads the
//   upstream val/msg (msg plus the increment, modulo 2^p_nbits); when rdy
//   is low it holds.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high; clears val and msg
//   prev_val  valid from the upstream stage (or the block input)
//   prev_msg  message from the upstream stage (or the block input)
//   rdy       this stage may advance this cycle
//   val       registered valid of this stage
//   msg       registered message of this stage
module regincr_stage_vr #(
    parameter int p_nbits = 8,
    parameter int p_incr  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               prev_val,
    input  logic [p_nbits-1:0] prev_msg,
    input  logic               rdy,
    output logic               val,
    output logic [p_nbits-1:0] msg
);

    // Increment truncated to the message width; the add below discards carry.
    localparam logic [p_nbits-1:0] incr = p_nbits'(p_incr);

    always_ff @(posedge clk) begin
        if (reset) begin
            val <= 1'b0;
            msg <= '0;
        end else if (rdy) begin
            val <= prev_val;
            msg <= prev_msg + incr;
        end
    end

endmodule

// File: rtl/regincr_nstage_vr.sv
// regincr_nstage_vr
//   Parametrised N-stage registered incrementer with val/rdy handshakes.
//   Every stage adds p_incr, so out_msg = in_msg + p_nstages*p_incr
//   (mod 2^p_nbits).  Latency is p_nstages with no backpressure and the
//   pipeline sustains one message per cycle; empty stages are always
//   ready so bubbles collapse under backpressure.
//
// Ports
//   clk      rising-edge clock
//   reset    synchronous, active-high; flushes every stage and count
//   in_val   upstream message valid
//   in_rdy   block can accept a message this cycle (combinational)
//   in_msg   upstream message
//   out_val  downstream message valid (registered, last stage)
//   out_rdy  downstream accepts a message this cycle
//   out_msg  incremented message (registered, last stage)
//   count    registered number of valid stages, 0..p_nstages
module regincr_nstage_vr
    import regincr_pkg::*;
#(
    parameter int p_nbits   = 8,
    parameter int p_nstages = 2,
    parameter int p_incr    = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_val,
    output logic                                 in_rdy,
    input  logic [p_nbits-1:0]                   in_msg,
    output logic                                 out_val,
    input  logic                                 out_rdy,
    output logic [p_nbits-1:0]                   out_msg,
    output logic [count_width(p_nstages)-1:0]    count
);

    localparam int cw = count_width(p_nstages);
    localparam logic [cw-1:0] one = cw'(1);

    logic [p_nstages-1:0] val;
    logic [p_nbits-1:0]   msg [p_nstages];
    logic [p_nstages-1:0] rdy;

    logic in_xfer;
    logic out_xfer;

    // rdy_i = !val_i || rdy_{i+1} unrolled to the tail: a stage can advance
    // unless it and every stage downstream of it are full and out_rdy is low.
    // The closed form keeps each rdy bit a function of flops and out_rdy only.
    for (genvar i = 0; i < p_nstages; i++) begin : g_stage
        logic               prev_val;
        logic [p_nbits-1:0] prev_msg;

        if (i == 0) begin : g_head
            assign prev_val = in_val;
            assign prev_msg = in_msg;
        end else begin : g_body
            assign prev_val = val[i-1];
            assign prev_msg = msg[i-1];
        end

        assign rdy[i] = out_rdy || !(&val[p_nstages-1:i]);

        regincr_stage_vr #(
            .p_nbits (p_nbits),
            .p_incr  (p_incr)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .prev_val (prev_val),
            .prev_msg (prev_msg),
            .rdy      (rdy[i]),
            .val      (val[i]),
            .msg      (msg[i])
        );
    end

    assign in_rdy  = rdy[0] && !reset;
    assign out_val = val[p_nstages-1];
    assign out_msg = msg[p_nstages-1];

    assign in_xfer  = in_val && in_rdy;
    assign out_xfer = out_val && out_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (in_xfer && !out_xfer) begin
            count <= count + one;
        end else if (out_xfer && !in_xfer) begin
            count <= count - one;
        end
    end

endmodule

// File: tb/tb_regincr_nstage_vr.sv
module tb_regincr_nstage_vr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- default DUT (8 bits, 2 stages, +1) ----------------
    logic       reset, in_val, in_rdy, out_val, out_rdy;
    logic [7:0] in_msg, out_msg;
    logic [1:0] count;

    regincr_nstage_vr dut (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
        .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg), .count(count)
    );

    // ---------------- 4 bits, 4 stages, +3 ----------------
    logic       rst2;
    logic       w_in_val, w_in_rdy, w_out_val, w_out_rdy;
    logic [3:0] w_in_msg, w_out_msg;
    logic [2:0] w_count;

    regincr_nstage_vr #(.p_nbits(4), .p_nstages(4), .p_incr(3)) dut_w (
        .clk(clk), .reset(rst2), .in_val(w_in_val), .in_rdy(w_in_rdy), .in_msg(w_in_msg),
        .out_val(w_out_val), .out_rdy(w_out_rdy), .out_msg(w_out_msg), .count(w_count)
    );

    // ---------------- 8 bits, 1 stage, +1 ----------------
    logic       s_in_val, s_in_rdy, s_out_val, s_out_rdy;
    logic [7:0] s_in_msg, s_out_msg;
    logic [0:0] s_count;

    regincr_nstage_vr #(.p_nbits(8), .p_nstages(1), .p_incr(1)) dut_s (
        .clk(clk), .reset(rst2), .in_val(s_in_val), .in_rdy(s_in_rdy), .in_msg(s_in_msg),
        .out_val(s_out_val), .out_rdy(s_out_rdy), .out_msg(s_out_msg), .count(s_count)
    );

    // ---------------- scoreboards ----------------
    typedef struct {
        logic [7:0] msg;
        int         cyc;
    } sb_t;

    sb_t        q[$];
    sb_t        e_main;
    bit         lat_on = 1'b0;

    logic [7:0] s_q[$];
    logic [7:0] s_exp;
    int         s_outs = 0;

    always @(negedge clk) begin
        if (!reset) begin
            check("count_vs_inflight", 32'(count), q.size());
            if (out_val && out_rdy) begin
                check("sb_nonempty", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    e_main = q.pop_front();
                    check("out_msg", 32'(out_msg), 32'(e_main.msg));
                    if (lat_on) check("latency", cyc - e_main.cyc, 2);
                end
            end
            if (in_val && in_rdy) q.push_back('{msg: 8'(in_msg + 8'd2), cyc: cyc});
        end
    end

    always @(negedge clk) begin
        if (!rst2) begin
            check("s_count", 32'(s_count), s_q.size());
            if (s_count == 1'b1) check("s_rdy_full", 32'(s_in_rdy), 32'(s_out_rdy));
            if (s_out_val && s_out_rdy) begin
                check("s_sb_nonempty", 32'(s_q.size() != 0), 1);
                if (s_q.size() != 0) begin
                    s_exp = s_q.pop_front();
                    check("s_out_msg", 32'(s_out_msg), 32'(s_exp));
                    s_outs++;
                end
            end
            if (s_in_val && s_in_rdy) s_q.push_back(8'(s_in_msg + 8'd1));
        end
    end

    // Offer one message on the default DUT until accepted (bounded).
    task automatic offer(input logic [7:0] m);
        bit acc;
        acc    = 1'b0;
        in_val = 1'b1;
        in_msg = m;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            acc = in_rdy;
            tick();
            if (acc) break;
        end
        if (!acc) check("offer_timeout", 0, 1);
        in_val = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 30; k++) begin
            if (q.size() == 0) break;
            tick();
        end
        check("drain", q.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [4:0] pat;

    initial begin
        reset = 1'b1; in_val = 1'b0; in_msg = '0; out_rdy = 1'b1;
        rst2 = 1'b1; w_in_val = 1'b0; w_in_msg = '0; w_out_rdy = 1'b1;
        s_in_val = 1'b0; s_in_msg = '0; s_out_rdy = 1'b1;

        // reset state
        @(negedge clk);
        check("in_rdy_in_reset", 32'(in_rdy), 0);
        tick();
        tick();
        reset = 1'b0;
        rst2  = 1'b0;
        #1;
        check("rst_out_val", 32'(out_val), 0);
        check("rst_out_msg", 32'(out_msg), 0);
        check("rst_count",   32'(count), 0);
        check("rst_in_rdy",  32'(in_rdy), 1);

        // 1: streaming with wrap-around
        lat_on = 1'b1;
        in_val = 1'b1; in_msg = 8'h00;
        @(negedge clk); check("t1_acc", 32'(in_rdy), 1); tick();
        in_msg = 8'h10;
        @(negedge clk); check("t1_count1", 32'(count), 1); tick();
        in_msg = 8'hFF;
        @(negedge clk); check("t1_count2a", 32'(count), 2); check("t1_out_val", 32'(out_val), 1); tick();
        in_val = 1'b0;
        @(negedge clk); check("t1_count2b", 32'(count), 2); tick();
        drain();

        // 2: backpressure fill, then same-cycle accept while draining
        lat_on  = 1'b0;
        out_rdy = 1'b0;
        offer(8'h05);
        offer(8'h06);
        in_val = 1'b1; in_msg = 8'h07;
        @(negedge clk);
        check("t2_full_in_rdy", 32'(in_rdy), 0);
        check("t2_full_count",  32'(count), 2);
        check("t2_hold_val",    32'(out_val), 1);
        tick();
        @(negedge clk); check("t2_still_full", 32'(in_rdy), 0); tick();
        out_rdy = 1'b1;
        @(negedge clk); check("t2_same_cycle_rdy", 32'(in_rdy), 1); tick();
        in_val = 1'b0;
        drain();

        // 3: bubbles propagate
        lat_on = 1'b1;
        pat = 5'b01101;
        for (int i = 0; i < 7; i++) begin
            logic ev;
            in_val = (i < 5) ? pat[i] : 1'b0;
            in_msg = 8'(8'h30 + i);
            ev = 1'b0;
            if (i >= 2) ev = pat[i-2];
            @(negedge clk);
            check("t3_out_val", 32'(out_val), 32'(ev));
            tick();
        end
        in_val = 1'b0;
        drain();

        // 4: reset with a full pipeline
        out_rdy = 1'b0;
        offer(8'h40);
        offer(8'h41);
        @(negedge clk); check("t4_full", 32'(count), 2);
        tick();
        reset = 1'b1; in_val = 1'b1; in_msg = 8'h42;
        @(negedge clk); check("t4_in_rdy_reset", 32'(in_rdy), 0);
        tick();
        reset = 1'b0; in_val = 1'b0;
        q.delete();
        #1;
        check("t4_out_val", 32'(out_val), 0);
        check("t4_out_msg", 32'(out_msg), 0);
        check("t4_count",   32'(count), 0);
        check("t4_in_rdy",  32'(in_rdy), 1);
        out_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); check("t4_no_stale", 32'(out_val), 0); tick();
        end

        // 5: 4-bit, 4-stage, +3 with wrap
        w_in_val = 1'b1; w_in_msg = 4'hE;
        @(negedge clk); check("t5_acc", 32'(w_in_rdy), 1); tick();
        w_in_val = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("t5_out_val", 32'(w_out_val), 32'(k == 4));
            if (k == 1) check("t5_count", 32'(w_count), 1);
            if (k == 4) check("t5_out_msg", 32'(w_out_msg), 32'h0000_000A);
            tick();
        end

        // 6: single stage with toggling out_rdy
        for (int m = 0; m < 4; m++) begin
            bit acc;
            acc = 1'b0;
            s_in_val = 1'b1;
            s_in_msg = 8'(m);
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                acc = s_in_rdy;
                tick();
                s_out_rdy = ~s_out_rdy;
                if (acc) break;
            end
            if (!acc) check("t6_offer_timeout", 0, 1);
        end
        s_in_val = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            s_out_rdy = ~s_out_rdy;
        end
        check("t6_outputs", s_outs, 4);
        check("t6_sb_empty", s_q.size(), 0);

        check("main_sb_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
